// File: rtl/sram_fifo_ctrl.sv
`default_nettype none
// sram_fifo_ctrl: FIFO controller for an external SRAM with a one-entry registered output stage.
// Revision 1.0
module sram_fifo_ctrl #(
   parameter int N = 32,
   parameter int D = 1024,
   parameter int A = $clog2(D)
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         flush,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [N-1:0] s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [N-1:0] m_data,
   output logic [A:0]   count,
   output logic         full,
   output logic         empty,
   output logic         mem_wren,
   output logic [A-1:0] mem_waddr,
   output logic [N-1:0] mem_wdata,
   output logic         mem_rden,
   output logic [A-1:0] mem_raddr,
   input  logic [N-1:0] mem_rdata
);

   localparam logic [A:0] DEPTH_C = (A+1)'(D);
   localparam logic [A:0] ONE_C   = {{A{1'b0}}, 1'b1};

   logic [A:0]   wptr_q, wptr_d;
   logic [A:0]   rptr_q, rptr_d;
   logic         ovalid_q, ovalid_d;
   logic [N-1:0] odata_q, odata_d;
   logic [A:0]   stored;
   logic         push;
   logic         load;

   // stored excludes the write in flight, so a word is never read in the cycle it is written
   assign stored  = wptr_q - rptr_q;
   assign full    = (stored == DEPTH_C);
   assign s_ready = !full && !flush && rstn;
   assign push    = s_valid && s_ready;
   assign load    = (stored != '0) && (!ovalid_q || m_ready) && !flush;

   assign mem_wren  = push;
   assign mem_waddr = wptr_q[A-1:0];
   assign mem_wdata = push ? s_data : '0;
   assign mem_rden  = load;
   assign mem_raddr = rptr_q[A-1:0];

   assign m_valid = ovalid_q;
   assign m_data  = odata_q;
   assign count   = stored + {{A{1'b0}}, ovalid_q};
   assign empty   = (count == '0);

   always_comb begin
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      ovalid_d = ovalid_q;
      odata_d  = odata_q;
      if (flush) begin
         wptr_d   = '0;
         rptr_d   = '0;
         ovalid_d = 1'b0;
      end else begin
         if (push) begin
            wptr_d = wptr_q + ONE_C;
         end
         if (load) begin
            rptr_d   = rptr_q + ONE_C;
            ovalid_d = 1'b1;
            odata_d  = mem_rdata;
         end else if (ovalid_q && m_ready) begin
            ovalid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         ovalid_q <= 1'b0;
         odata_q  <= '0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         ovalid_q <= ovalid_d;
         odata_q  <= odata_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
`default_nettype none
// tb_sram_fifo_ctrl: directed scenarios with a scoreboard queue checked by an output monitor.
// Revision 1.0
module tb_sram_fifo_ctrl;

   logic        clk;
   logic        rstn;
   logic        flush;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic [2:0]  count;
   logic        full;
   logic        empty;
   logic        mem_wren;
   logic [1:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        mem_rden;
   logic [1:0]  mem_raddr;
   logic [31:0] mem_rdata;

   logic [31:0] mem [4];
   logic [31:0] sb [$];
   logic [31:0] mon_exp;
   int          vectors;
   int          miscompares;

   sram_fifo_ctrl #(.N(32), .D(4)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .mem_wren  (mem_wren),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .mem_rden  (mem_rden),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // SRAM model: synchronous write, combinational read
   always @(posedge clk) begin
      if (mem_wren) mem[mem_waddr] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_raddr];

   // Expected-word recorder: every accepted push enters the scoreboard
   always @(negedge clk) begin
      if (!rstn || flush) sb.delete();
      else if (s_valid && s_ready) sb.push_back(s_data);
   end

   // Output monitor: every output handshake pops and compares
   always @(negedge clk) begin
      if (rstn && !flush && m_valid && m_ready) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL pop_unexpected: got %h, expected no output", m_data);
         end else begin
            mon_exp = sb.pop_front();
            if (m_data !== mon_exp) begin
               miscompares++;
               $display("FAIL pop_data: got %h, expected %h", m_data, mon_exp);
            end
         end
      end
   end

   task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_b(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_checks(input string n);
      chk_b({n, "_m_valid"}, m_valid, 1'b0);
      chk_w({n, "_count"}, 32'(count), 32'd0);
      chk_b({n, "_empty"}, empty, 1'b1);
      chk_b({n, "_full"}, full, 1'b0);
      chk_b({n, "_s_ready"}, s_ready, 1'b0);
      chk_b({n, "_wren"}, mem_wren, 1'b0);
      chk_b({n, "_rden"}, mem_rden, 1'b0);
      chk_w({n, "_m_data"}, m_data, 32'd0);
      chk_w({n, "_waddr"}, 32'(mem_waddr), 32'd0);
      chk_w({n, "_raddr"}, 32'(mem_raddr), 32'd0);
      chk_w({n, "_wdata"}, mem_wdata, 32'd0);
   endtask

   task automatic single_word(input string n);
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = 32'hA5A5_0001;
      @(negedge clk);
      chk_b({n, "_wren"}, mem_wren, 1'b1);
      chk_w({n, "_waddr"}, 32'(mem_waddr), 32'd0);
      chk_w({n, "_wdata"}, mem_wdata, 32'hA5A5_0001);
      step();
      s_valid = 1'b0;
      @(negedge clk);
      chk_b({n, "_m_valid_edge1"}, m_valid, 1'b0);
      step();
      @(negedge clk);
      chk_b({n, "_m_valid_edge2"}, m_valid, 1'b1);
      chk_w({n, "_m_data"}, m_data, 32'hA5A5_0001);
      chk_w({n, "_count"}, 32'(count), 32'd1);
      step();
      m_ready = 1'b1;
      @(negedge clk);
      step();
      m_ready = 1'b0;
      @(negedge clk);
      chk_b({n, "_empty"}, empty, 1'b1);
      step();
   endtask

   task automatic drain(input string n);
      m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (empty) break;
         step();
      end
      chk_b({n, "_drain_empty"}, empty, 1'b1);
      chk_w({n, "_drain_left"}, 32'(sb.size()), 32'd0);
      step();
      m_ready = 1'b0;
   endtask

   task automatic push_words(input logic [31:0] base, input int num);
      for (int i = 0; i < num; i++) begin
         s_valid = 1'b1;
         s_data  = base + 32'(i);
         step();
      end
      s_valid = 1'b0;
   endtask

   logic        bp_ready [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   logic [31:0] bp_data  [4] = '{32'h100, 32'h101, 32'h101, 32'h101};

   initial begin
      clk = 1'b0; rstn = 1'b0; flush = 1'b0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      vectors = 0; miscompares = 0;

      repeat (2) @(negedge clk);
      reset_checks("rst");
      step();
      rstn = 1'b1;
      single_word("sw");

      // Fill: six offers against a stalled consumer, only five fit
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         s_valid = 1'b1;
         s_data  = 32'(i + 1);
         @(negedge clk);
         chk_b("fill_s_ready", s_ready, 1'(i < 5));
         step();
      end
      s_valid = 1'b0;
      @(negedge clk);
      chk_b("fill_full", full, 1'b1);
      chk_b("fill_s_ready_end", s_ready, 1'b0);
      chk_w("fill_count", 32'(count), 32'd5);
      chk_w("fill_m_data", m_data, 32'd1);
      step();
      drain("fill");

      // Return pointers to zero so the wrap sequence starts at address 0
      flush = 1'b1;
      @(negedge clk);
      step();
      flush = 1'b0;

      for (int i = 0; i < 12; i++) begin
         s_valid = 1'b1;
         s_data  = 32'(i);
         m_ready = 1'b1;
         @(negedge clk);
         chk_w("wrap_waddr", 32'(mem_waddr), 32'(i % 4));
         chk_b("wrap_m_valid", m_valid, 1'(i >= 2));
         step();
      end
      s_valid = 1'b0;
      drain("wrap");

      // Backpressure
      m_ready = 1'b0;
      push_words(32'h100, 3);
      for (int k = 0; k < 4; k++) begin
         m_ready = bp_ready[k];
         @(negedge clk);
         chk_b("bp_m_valid", m_valid, 1'b1);
         chk_w("bp_m_data", m_data, bp_data[k]);
         step();
      end
      drain("bp");

      // Flush with three words held and a push offered
      m_ready = 1'b0;
      push_words(32'h200, 3);
      @(negedge clk);
      chk_w("fl_count_before", 32'(count), 32'd3);
      step();
      flush   = 1'b1;
      s_valid = 1'b1;
      s_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      chk_b("fl_wren", mem_wren, 1'b0);
      chk_b("fl_rden", mem_rden, 1'b0);
      chk_b("fl_s_ready", s_ready, 1'b0);
      step();
      flush   = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      chk_w("fl_count", 32'(count), 32'd0);
      chk_b("fl_m_valid", m_valid, 1'b0);
      chk_b("fl_empty", empty, 1'b1);
      step();
      s_valid = 1'b1;
      s_data  = 32'h300;
      @(negedge clk);
      chk_b("fl_next_wren", mem_wren, 1'b1);
      chk_w("fl_next_waddr", 32'(mem_waddr), 32'd0);
      step();
      s_valid = 1'b0;
      drain("fl");

      // Asynchronous reset mid-cycle with four words held
      m_ready = 1'b0;
      push_words(32'h400, 4);
      @(negedge clk);
      chk_w("ar_count_before", 32'(count), 32'd4);
      #2;
      rstn    = 1'b0;
      s_valid = 1'b1;
      s_data  = 32'h4FF;
      #1;
      chk_b("ar_m_valid", m_valid, 1'b0);
      chk_w("ar_count", 32'(count), 32'd0);
      chk_b("ar_s_ready", s_ready, 1'b0);
      @(negedge clk);
      reset_checks("ar_hold");
      step();
      s_valid = 1'b0;
      rstn    = 1'b1;
      single_word("ar_sw");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 Parameters SHALL be:
- N: default 32; data width in bits.
- D: default 1024; memory depth, power of two, ≥2.
- A: default $clog2(D); memory address width.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  core clock, single clock domain.
- rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous discard of all contents.
- s_valid  in  1  producer data valid.
- s_ready  out  1  controller can accept a word.
- s_data  in  N  producer data.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word.
- m_data  out  N  output word, registered.
- count  out  A+1  words held: memory plus output register.
- full  out  1  memory holds D words.
- empty  out  1  count==0.
- mem_wren  out  1  drives memory write enable.
- mem_waddr  out  A  drives memory write address.
- mem_wdata  out  N  drives memory write data.
- mem_rden  out  1  drives memory read enable.
- mem_raddr  out  A  drives memory read address.
- mem_rdata  in  N  memory read data; combinational from mem_raddr/mem_rden.

Function
REQ-003 The block SHALL keep A+1-bit pointers wptr and rptr; the low A bits address memory and the MSB is a wrap bit. Stored word count SHALL be stored = wptr - rptr, modulo 2^(A+1).
REQ-004 full SHALL be (stored==D); s_ready SHALL be !full && !flush && rstn.
REQ-005 Push: when s_valid && s_ready, the block SHALL in the same cycle drive mem_wren=1, mem_waddr=wptr[A-1:0] and mem_wdata=s_data, and SHALL increment wptr at that clock edge. Otherwise mem_wren SHALL be 0.
REQ-006 Output stage: a one-entry register (ovalid, odata) SHALL drive m_valid and m_data.
REQ-007 Load: load = (stored>0) && (!ovalid || m_ready) && !flush. On load the block SHALL drive mem_rden=1 and mem_raddr=rptr[A-1:0], SHALL capture odata<=mem_rdata and set ovalid<=1 at the edge, and SHALL increment rptr. Otherwise mem_rden SHALL be 0.
REQ-008 Pop without load: if m_valid && m_ready && !load, ovalid SHALL clear at the edge.
REQ-009 While m_valid && !m_ready, m_data SHALL be held stable.
REQ-010 A word written in cycle T SHALL NOT be read before cycle T+1, because stored excludes the in-flight write. The same address SHALL never be read and written in one cycle.
REQ-011 Latency from acceptance in cycle 0 to m_valid SHALL be 2 clock edges when the output stage is empty.
REQ-012 Throughput SHALL be one push and one pop per cycle sustained; a push and a load in the same cycle SHALL both occur and stored SHALL be unchanged.
REQ-013 count SHALL equal stored + ovalid, with range 0..D+1. empty SHALL be (count==0).
REQ-014 Pointer wrap: incrementing past index D-1 SHALL return the address to 0 and toggle the MSB. No overflow or underflow SHALL occur, because s_ready and load guard all increments.
REQ-015 Flush SHALL have priority over push and pop. At the edge with flush=1: wptr=rptr=0, ovalid=0, odata unchanged. mem_wren and mem_rden SHALL be 0 during the flush cycle.

Reset
REQ-016 While rstn=0, asynchronously: wptr=rptr=0, ovalid=0, m_data=0. Hence m_valid=0, count=0, empty=1, full=0.
REQ-017 While rstn=0: s_ready=0, mem_wren=0, mem_rden=0, mem_waddr=0, mem_raddr=0, mem_wdata=0.
REQ-018 Assertion of rstn mid-stream SHALL discard all contents. Deassertion SHALL take effect at the first clk edge after release, with no spurious push or pop.

Verification
REQ-019 The bench SHALL cover these directed scenarios, with D=4 and N=32 unless stated:
- Single word: after reset, push 0xA5A50001 in cycle 0 -> mem_wren=1 and mem_waddr=0 in cycle 0; m_valid=1 and m_data=0xA5A50001 after the 2nd edge; count=1.
- Fill: m_ready=0, s_valid=1 for 6 cycles with data 1..6 -> words 1..5 accepted; full=1, s_ready=0, count=5, m_data=1.
- Wrap and order: stream 0..11 with s_valid=m_ready=1 -> outputs 0..11 in order, one per cycle after the 2-cycle fill; mem_waddr sequence 0,1,2,3,0,...
- Backpressure: toggle m_ready 1,0,0,1 with 3 words queued -> m_data held while m_ready=0; no loss, no duplication.
- Flush: with count=3, pulse flush for 1 cycle with s_valid=1 -> no push; next cycle count=0, m_valid=0, empty=1; the next push writes address 0.
- Async reset: drop rstn mid-cycle with count=4 -> m_valid, count and s_ready go to 0 before the next edge; after release, operation matches the single-word scenario.
